// File: rtl/cnn_pkg.sv
// Shared sizes and types for the CNN result reader and its score comparator.
package cnn_pkg;

    localparam int NUM_CLASSES = 10;
    localparam int SCORE_W     = 32;
    localparam int IDX_W       = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        RESULT = 2'd2
    } rd_state_t;

    typedef logic signed [SCORE_W-1:0] score_t;

endpackage

// File: rtl/cnn_score_cmp.sv
// Signed strict-greater compare of a candidate against the running best.
// Ties keep the incumbent, so a serial scan favours the lowest index.
module cnn_score_cmp #(
    parameter int SCORE_W = cnn_pkg::SCORE_W,
    parameter int IDX_W   = cnn_pkg::IDX_W
) (
    input  logic signed [SCORE_W-1:0] cand,
    input  logic        [IDX_W-1:0]   cand_idx,
    input  logic signed [SCORE_W-1:0] best,
    input  logic        [IDX_W-1:0]   best_idx,
    output logic signed [SCORE_W-1:0] sel_score,
    output logic        [IDX_W-1:0]   sel_idx
);

    always_comb begin
        sel_score = best;
        sel_idx   = best_idx;
        if (cand > best) begin
            sel_score = cand;
            sel_idx   = cand_idx;
        end
    end

endmodule

// File: rtl/cnn_result_reader.sv
// Captures the accelerator score bus on a done edge, scans it serially for the
// argmax class, and presents the result on a valid/ready handshake.
//
//   state  | meaning
//   IDLE   | waiting for a done edge; an edge captures the scores
//   SCAN   | comparing score[k] against the running best, k = 1..NUM_CLASSES-1
//   RESULT | o_valid high until accepted; an edge on the accept cycle rescans
module cnn_result_reader #(
    parameter int NUM_CLASSES = cnn_pkg::NUM_CLASSES,
    parameter int SCORE_W     = cnn_pkg::SCORE_W,
    parameter int IDX_W       = cnn_pkg::IDX_W
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [SCORE_W*NUM_CLASSES-1:0] i_scores,
    input  logic                           i_done,
    output logic [IDX_W-1:0]               o_class,
    output logic [SCORE_W-1:0]             o_max_score,
    output logic                           o_valid,
    input  logic                           i_ready,
    input  logic [IDX_W-1:0]               i_rd_addr,
    output logic [SCORE_W-1:0]             o_rd_data,
    output logic                           o_busy,
    output logic                           o_overrun
);

    import cnn_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);
    localparam logic [IDX_W-1:0] NUM_IDX  = IDX_W'(NUM_CLASSES);

    rd_state_t state;
    rd_state_t state_nxt;

    logic                      done_q;
    logic                      done_edge;
    logic                      handshake;
    logic                      capture;
    logic                      overrun_set;
    logic                      result_load;
    logic                      valid_nxt;
    logic                      busy_nxt;

    logic signed [SCORE_W-1:0] score_buf [NUM_CLASSES];
    logic signed [SCORE_W-1:0] best;
    logic        [IDX_W-1:0]   best_idx;
    logic        [IDX_W-1:0]   k;
    logic signed [SCORE_W-1:0] cmp_score;
    logic        [IDX_W-1:0]   cmp_idx;

    assign done_edge = i_done & ~done_q;
    assign handshake = o_valid & i_ready;

    cnn_score_cmp #(
        .SCORE_W (SCORE_W),
        .IDX_W   (IDX_W)
    ) u_score_cmp (
        .cand      (score_buf[k]),
        .cand_idx  (k),
        .best      (best),
        .best_idx  (best_idx),
        .sel_score (cmp_score),
        .sel_idx   (cmp_idx)
    );

    // State register; o_valid/o_busy are registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            o_valid   <= 1'b0;
            o_busy    <= 1'b0;
            o_overrun <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state   <= state_nxt;
            o_valid <= valid_nxt;
            o_busy  <= busy_nxt;
            done_q  <= i_done;
            if (overrun_set) begin
                o_overrun <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (done_edge) state_nxt = SCAN;
            SCAN:    if (k == LAST_IDX) state_nxt = RESULT;
            RESULT:  if (handshake) state_nxt = done_edge ? SCAN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        capture     = 1'b0;
        overrun_set = 1'b0;
        result_load = 1'b0;
        case (state)
            IDLE: capture = done_edge;
            SCAN: begin
                overrun_set = done_edge;
                result_load = (k == LAST_IDX);
            end
            RESULT: begin
                capture     = done_edge & handshake;
                overrun_set = done_edge & ~handshake;
            end
            default: ;
        endcase
        valid_nxt = (state_nxt == RESULT);
        busy_nxt  = (state_nxt != IDLE);
    end

    // Buffer, scan datapath and readback. Readback in the capture cycle sees
    // the old contents because the buffer update lands on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                score_buf[i] <= '0;
            end
            best        <= '0;
            best_idx    <= '0;
            k           <= '0;
            o_class     <= '0;
            o_max_score <= '0;
            o_rd_data   <= '0;
        end else begin
            o_rd_data <= (i_rd_addr < NUM_IDX) ? score_buf[i_rd_addr] : '0;
            if (capture) begin
                for (int i = 0; i < NUM_CLASSES; i++) begin
                    score_buf[i] <= i_scores[i*SCORE_W +: SCORE_W];
                end
                best     <= i_scores[SCORE_W-1:0];
                best_idx <= '0;
                k        <= IDX_W'(1);
            end else if (state == SCAN) begin
                best     <= cmp_score;
                best_idx <= cmp_idx;
                k        <= k + IDX_W'(1);
            end
            if (result_load) begin
                o_class     <= cmp_idx;
                o_max_score <= cmp_score;
            end
        end
    end

endmodule

// File: tb/tb_cnn_result_reader.sv
// Scenario bench for cnn_result_reader: expected argmax results are queued when
// a done edge is driven and compared when o_valid is observed.
module tb_cnn_result_reader;

    import cnn_pkg::*;

    localparam int NC = NUM_CLASSES;

    typedef struct packed {
        logic [IDX_W-1:0]   cls;
        logic [SCORE_W-1:0] score;
    } exp_t;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [SCORE_W*NC-1:0]     i_scores;
    logic                      i_done;
    logic                      i_ready;
    logic [IDX_W-1:0]          i_rd_addr;
    logic [IDX_W-1:0]          o_class;
    logic [SCORE_W-1:0]        o_max_score;
    logic                      o_valid;
    logic [SCORE_W-1:0]        o_rd_data;
    logic                      o_busy;
    logic                      o_overrun;

    int   pass_cnt  = 0;
    int   total_cnt = 0;
    exp_t exp_q[$];

    cnn_result_reader dut (
        .clk         (clk),
        .reset       (reset),
        .i_scores    (i_scores),
        .i_done      (i_done),
        .o_class     (o_class),
        .o_max_score (o_max_score),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .i_rd_addr   (i_rd_addr),
        .o_rd_data   (o_rd_data),
        .o_busy      (o_busy),
        .o_overrun   (o_overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [SCORE_W*NC-1:0] pack_scores(input score_t s [NC]);
        logic [SCORE_W*NC-1:0] v;
        for (int i = 0; i < NC; i++) v[i*SCORE_W +: SCORE_W] = s[i];
        return v;
    endfunction

    function automatic exp_t model_argmax(input score_t s [NC]);
        exp_t   e;
        score_t b;
        int     bi;
        b  = s[0];
        bi = 0;
        for (int i = 1; i < NC; i++) begin
            if (s[i] > b) begin
                b  = s[i];
                bi = i;
            end
        end
        e.cls   = IDX_W'(bi);
        e.score = b;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a one-cycle done pulse; returns in cycle 1 of the scan.
    task automatic start_scan(input score_t s [NC]);
        i_scores = pack_scores(s);
        exp_q.push_back(model_argmax(s));
        i_done = 1'b1;
        tick();
        i_done = 1'b0;
    endtask

    // Called in cycle 1 after the edge; cyc ends as the cycle o_valid is seen.
    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (!o_valid && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; i_done = 1'b0; i_ready = 1'b0; i_rd_addr = '0; i_scores = '0;
        repeat (3) tick();
        total_cnt++; if ({o_valid, o_busy, o_overrun} !== 3'b000) $display("FAIL reset_flags got=%b exp=000", {o_valid, o_busy, o_overrun}); else pass_cnt++;
        total_cnt++; if ({o_class, o_max_score, o_rd_data} !== '0) $display("FAIL reset_data got class=%0d max=%0h rd=%0h exp=0", o_class, o_max_score, o_rd_data); else pass_cnt++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic_argmax();
        score_t s [NC];
        exp_t   e;
        int     cyc;
        s = '{32'sd5, -32'sd3, 32'sd100, 32'sd7, 32'sd0, 32'sd2, 32'sd99, -32'sd100, 32'sd1, 32'sd4};
        i_ready = 1'b1;
        start_scan(s);
        total_cnt++; if (o_busy !== 1'b1) $display("FAIL basic_busy got=%b exp=1", o_busy); else pass_cnt++;
        wait_valid(cyc);
        e = exp_q.pop_front();
        total_cnt++; if (cyc !== 10) $display("FAIL basic_latency got=%0d exp=10", cyc); else pass_cnt++;
        total_cnt++; if (o_class !== e.cls || o_class !== 4'd2) $display("FAIL basic_class got=%0d exp=%0d", o_class, e.cls); else pass_cnt++;
        total_cnt++; if (o_max_score !== e.score || o_max_score !== 32'd100) $display("FAIL basic_score got=%0d exp=%0d", o_max_score, e.score); else pass_cnt++;
        tick();
        total_cnt++; if ({o_valid, o_busy} !== 2'b00) $display("FAIL basic_drop got valid/busy=%b exp=00", {o_valid, o_busy}); else pass_cnt++;
    endtask

    task automatic test_negative_tie();
        score_t s [NC];
        exp_t   e;
        int     cyc;
        for (int i = 0; i < NC; i++) s[i] = -32'sd8;
        s[3] = -32'sd1;
        s[7] = -32'sd1;
        i_ready = 1'b1;
        start_scan(s);
        wait_valid(cyc);
        e = exp_q.pop_front();
        total_cnt++; if (o_class !== e.cls || o_class !== 4'd3) $display("FAIL tie_class got=%0d exp=%0d", o_class, e.cls); else pass_cnt++;
        total_cnt++; if (o_max_score !== e.score || o_max_score !== 32'hFFFF_FFFF) $display("FAIL tie_score got=%0h exp=%0h", o_max_score, e.score); else pass_cnt++;
        tick();
    endtask

    task automatic test_backpressure_overrun();
        score_t a [NC];
        score_t b [NC];
        exp_t   e;
        int     cyc;
        logic   stable;
        for (int i = 0; i < NC; i++) begin
            a[i] = score_t'($urandom);
            b[i] = score_t'($urandom);
        end
        b[0] = a[0] + 32'sd1;
        i_ready = 1'b0;
        start_scan(a);
        wait_valid(cyc);
        e = exp_q.pop_front();
        total_cnt++; if (cyc !== 10) $display("FAIL bp_latency got=%0d exp=10", cyc); else pass_cnt++;
        stable = 1'b1;
        for (int c = 11; c <= 29; c++) begin
            if (c == 15) begin
                i_scores = pack_scores(b);
                i_done   = 1'b1;
            end else begin
                i_done = 1'b0;
            end
            tick();
            if (o_valid !== 1'b1 || o_class !== e.cls || o_max_score !== e.score) stable = 1'b0;
        end
        total_cnt++; if (stable !== 1'b1) $display("FAIL bp_stable got class=%0d max=%0h valid=%b exp class=%0d max=%0h valid=1", o_class, o_max_score, o_valid, e.cls, e.score); else pass_cnt++;
        total_cnt++; if (o_overrun !== 1'b1) $display("FAIL bp_overrun got=%b exp=1", o_overrun); else pass_cnt++;
        i_rd_addr = 4'd0;
        tick();
        total_cnt++; if (o_rd_data !== a[0]) $display("FAIL bp_readback0 got=%0h exp=%0h", o_rd_data, a[0]); else pass_cnt++;
        i_rd_addr = 4'd9;
        tick();
        total_cnt++; if (o_rd_data !== a[9]) $display("FAIL bp_readback9 got=%0h exp=%0h", o_rd_data, a[9]); else pass_cnt++;
        i_ready = 1'b1;
        tick();
        total_cnt++; if ({o_valid, o_busy} !== 2'b00) $display("FAIL bp_idle got valid/busy=%b exp=00", {o_valid, o_busy}); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        score_t a [NC];
        score_t b [NC];
        exp_t   e;
        int     cyc;
        for (int i = 0; i < NC; i++) begin
            a[i] = score_t'($urandom);
            b[i] = score_t'($urandom);
        end
        i_ready = 1'b0;
        start_scan(a);
        wait_valid(cyc);
        e = exp_q.pop_front();
        total_cnt++; if (o_class !== e.cls || o_max_score !== e.score) $display("FAIL b2b_first got class=%0d max=%0h exp class=%0d max=%0h", o_class, o_max_score, e.cls, e.score); else pass_cnt++;
        // Accept the result and raise a new done edge in the same cycle.
        i_ready  = 1'b1;
        i_scores = pack_scores(b);
        exp_q.push_back(model_argmax(b));
        i_done   = 1'b1;
        tick();
        i_done  = 1'b0;
        i_ready = 1'b0;
        total_cnt++; if ({o_valid, o_busy} !== 2'b01) $display("FAIL b2b_rescan got valid/busy=%b exp=01", {o_valid, o_busy}); else pass_cnt++;
        wait_valid(cyc);
        e = exp_q.pop_front();
        total_cnt++; if (cyc !== 10) $display("FAIL b2b_latency got=%0d exp=10", cyc); else pass_cnt++;
        total_cnt++; if (o_class !== e.cls || o_max_score !== e.score) $display("FAIL b2b_second got class=%0d max=%0h exp class=%0d max=%0h", o_class, o_max_score, e.cls, e.score); else pass_cnt++;
        i_rd_addr = 4'd6;
        tick();
        total_cnt++; if (o_rd_data !== b[6]) $display("FAIL rd_addr6 got=%0h exp=%0h", o_rd_data, b[6]); else pass_cnt++;
        i_rd_addr = 4'd12;
        tick();
        total_cnt++; if (o_rd_data !== 32'd0) $display("FAIL rd_addr12 got=%0h exp=0", o_rd_data); else pass_cnt++;
        i_ready = 1'b1;
        tick();
    endtask

    task automatic test_readback_capture();
        score_t c [NC];
        exp_t   e;
        int     cyc;
        logic [SCORE_W-1:0] old2;
        tick();
        i_rd_addr = 4'd2;
        tick();
        old2 = o_rd_data;
        for (int i = 0; i < NC; i++) c[i] = score_t'($urandom);
        c[2] = ~old2;
        i_ready = 1'b1;
        start_scan(c);
        total_cnt++; if (o_rd_data !== old2) $display("FAIL rd_capture_old got=%0h exp=%0h", o_rd_data, old2); else pass_cnt++;
        tick();
        total_cnt++; if (o_rd_data !== c[2]) $display("FAIL rd_capture_new got=%0h exp=%0h", o_rd_data, c[2]); else pass_cnt++;
        wait_valid(cyc);
        e = exp_q.pop_front();
        total_cnt++; if (o_class !== e.cls || o_max_score !== e.score) $display("FAIL rd_result got class=%0d max=%0h exp class=%0d max=%0h", o_class, o_max_score, e.cls, e.score); else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_mid_scan();
        score_t a [NC];
        score_t b [NC];
        exp_t   e;
        int     cyc;
        for (int i = 0; i < NC; i++) begin
            a[i] = score_t'($urandom);
            b[i] = score_t'($urandom);
        end
        i_ready   = 1'b1;
        i_rd_addr = 4'd1;
        i_scores  = pack_scores(a);
        i_done    = 1'b1;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        total_cnt++; if ({o_valid, o_busy, o_overrun} !== 3'b000) $display("FAIL rst_scan_flags got=%b exp=000", {o_valid, o_busy, o_overrun}); else pass_cnt++;
        total_cnt++; if ({o_class, o_max_score, o_rd_data} !== '0) $display("FAIL rst_scan_data got class=%0d max=%0h rd=%0h exp=0", o_class, o_max_score, o_rd_data); else pass_cnt++;
        i_scores = pack_scores(b);
        exp_q.push_back(model_argmax(b));
        tick();
        reset = 1'b0;
        tick();
        total_cnt++; if (o_busy !== 1'b1) $display("FAIL rst_recapture_busy got=%b exp=1", o_busy); else pass_cnt++;
        wait_valid(cyc);
        e = exp_q.pop_front();
        total_cnt++; if (cyc !== 10) $display("FAIL rst_latency got=%0d exp=10", cyc); else pass_cnt++;
        total_cnt++; if (o_class !== e.cls || o_max_score !== e.score) $display("FAIL rst_result got class=%0d max=%0h exp class=%0d max=%0h", o_class, o_max_score, e.cls, e.score); else pass_cnt++;
        i_done = 1'b0;
        tick();
        total_cnt++; if ({o_valid, o_busy, o_overrun} !== 3'b000) $display("FAIL rst_final got=%b exp=000", {o_valid, o_busy, o_overrun}); else pass_cnt++;
        total_cnt++; if (exp_q.size() !== 0) $display("FAIL queue_empty got=%0d exp=0", exp_q.size()); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic_argmax();
        test_negative_tie();
        test_backpressure_overrun();
        test_back_to_back();
        test_readback_capture();
        test_reset_mid_scan();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0d checks", total_cnt);
        $fatal(1, "watchdog");
    end

endmodule
